rgb2yuv: RTL

RGB2YUV -- requirements
Module: rgb2yuv

---
 rtl/rgb2yuv.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rgb2yuv.sv
// rgb2yuv: 3-stage full-range BT.601 RGB->YUV converter with bypass, sideband delay and no backpressure.
// Define RGB2YUV_YSUM_EN to add the per-frame luma accumulator outputs y_sum / y_sum_valid.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h2
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h3
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h4
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'h8
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h8
`endif

module rgb2yuv #(
  parameter int unsigned UV_OFFSET = 128
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [15:0]             meta_datai,
  input  logic [7:0]              ri,
  input  logic [7:0]              gi,
  input  logic [7:0]              bi,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]             meta_datao,
  output logic [7:0]              yo,
  output logic [7:0]              uo,
  output logic [7:0]              vo
`ifdef RGB2YUV_YSUM_EN
  ,
  output logic [31:0]             y_sum,
  output logic                    y_sum_valid
`endif
);

  localparam int DW = `DTYPE_WIDTH;
  localparam logic signed [17:0] UV_OFF = 18'(UV_OFFSET);
  localparam logic signed [17:0] ROUND  = 18'sd128;

  // Zero-extend an unsigned 16b product into the signed 18b sum domain.
  function automatic logic signed [17:0] ext(input logic [15:0] p);
    return $signed({2'b00, p});
  endfunction

  // Floor-shift out the 8 fraction bits, add the offset and clamp to 0..255.
  function automatic logic [7:0] sat8(input logic signed [17:0] s,
                                      input logic signed [17:0] off);
    logic signed [17:0] v;
    v = (s >>> 8) + off;
    if (v < 18'sd0)
      return 8'd0;
    else if (v > 18'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // Stage 1: sideband, enable, raw pixel and the nine unsigned products.
  logic          s1_dv, s1_en;
  logic [DW-1:0] s1_dtype;
  logic [15:0]   s1_meta;
  logic [7:0]    s1_r, s1_g, s1_b;
  logic [15:0]   s1_yr, s1_yg, s1_yb;
  logic [15:0]   s1_ur, s1_ug, s1_ub;
  logic [15:0]   s1_vr, s1_vg, s1_vb;

  // Stage 2: sideband, enable, raw pixel and the three signed sums.
  logic                s2_dv, s2_en;
  logic [DW-1:0]       s2_dtype;
  logic [15:0]         s2_meta;
  logic [7:0]          s2_r, s2_g, s2_b;
  logic signed [17:0]  s2_ys, s2_us, s2_vs;

  // NOTE: every pipeline register is reset, so a mid-stream reset discards in-flight beats
  // and no stale dvo can emerge afterwards; all state uses non-blocking assignment.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_dv    <= 1'b0;
      s1_en    <= 1'b0;
      s1_dtype <= '0;
      s1_meta  <= '0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_yr    <= '0;
      s1_yg    <= '0;
      s1_yb    <= '0;
      s1_ur    <= '0;
      s1_ug    <= '0;
      s1_ub    <= '0;
      s1_vr    <= '0;
      s1_vg    <= '0;
      s1_vb    <= '0;
    end else begin
      s1_dv    <= dvi;
      s1_en    <= enable;
      s1_dtype <= dtypei;
      s1_meta  <= meta_datai;
      s1_r     <= ri;
      s1_g     <= gi;
      s1_b     <= bi;
      s1_yr    <= 16'(ri) * 16'd77;
      s1_yg    <= 16'(gi) * 16'd150;
      s1_yb    <= 16'(bi) * 16'd29;
      s1_ur    <= 16'(ri) * 16'd43;
      s1_ug    <= 16'(gi) * 16'd85;
      s1_ub    <= 16'(bi) * 16'd128;
      s1_vr    <= 16'(ri) * 16'd128;
      s1_vg    <= 16'(gi) * 16'd107;
      s1_vb    <= 16'(bi) * 16'd21;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s2_dv    <= 1'b0;
      s2_en    <= 1'b0;
      s2_dtype <= '0;
      s2_meta  <= '0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_ys    <= '0;
      s2_us    <= '0;
      s2_vs    <= '0;
    end else begin
      s2_dv    <= s1_dv;
      s2_en    <= s1_en;
      s2_dtype <= s1_dtype;
      s2_meta  <= s1_meta;
      s2_r     <= s1_r;
      s2_g     <= s1_g;
      s2_b     <= s1_b;
      s2_ys    <= ext(s1_yr) + ext(s1_yg) + ext(s1_yb) + ROUND;
      s2_us    <= ext(s1_ub) - ext(s1_ur) - ext(s1_ug) + ROUND;
      s2_vs    <= ext(s1_vr) - ext(s1_vg) - ext(s1_vb) + ROUND;
    end
  end

  // Stage 3: scale/offset/saturate, or bypass the raw pixel unchanged.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dvo        <= 1'b0;
      dtypeo     <= '0;
      meta_datao <= '0;
      yo         <= '0;
      uo         <= '0;
      vo         <= '0;
    end else begin
      dvo        <= s2_dv;
      dtypeo     <= s2_dtype;
      meta_datao <= s2_meta;
      if (s2_en) begin
        yo <= sat8(s2_ys, 18'sd0);
        uo <= sat8(s2_us, UV_OFF);
        vo <= sat8(s2_vs, UV_OFF);
      end else begin
        yo <= s2_r;
        uo <= s2_g;
        vo <= s2_b;
      end
    end
  end

`ifdef RGB2YUV_YSUM_EN
  logic [31:0] y_acc;
  logic        out_fs, out_fe, out_pix;

  always_comb begin
    out_fs  = dvo && (dtypeo == `DTYPE_FRAME_START);
    out_fe  = dvo && (dtypeo == `DTYPE_FRAME_END);
    out_pix = dvo && ((dtypeo & `DTYPE_PIXEL_MASK) != '0);
  end

  // Accumulates the output-side luma; the total is published one cycle after FRAME_END.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      y_acc       <= '0;
      y_sum       <= '0;
      y_sum_valid <= 1'b0;
    end else begin
      if (out_fs)
        y_acc <= '0;
      else if (out_pix)
        y_acc <= y_acc + {24'd0, yo};
      y_sum_valid <= out_fe;
      if (out_fe)
        y_sum <= y_acc;
    end
  end
`endif

endmodule
